// File: rtl/internal_framebuffer_stream_loader.sv
// Streams AXI-Stream pixel beats into the internal framebuffer RAM write port,
// applying scissor and per-sub-pixel colour mask, under the apply/applied handshake.
module internal_framebuffer_stream_loader #(
    parameter int NUMBER_OF_PIXELS_PER_BEAT    = 2,
    parameter int NUMBER_OF_SUB_PIXELS         = 4,
    parameter int SUB_PIXEL_WIDTH              = 8,
    parameter int X_BIT_WIDTH                  = 11,
    parameter int Y_BIT_WIDTH                  = 11,
    parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
    parameter int FB_SIZE_IN_PIXEL_LG          = 20,
    localparam int PPB_LG         = $clog2(NUMBER_OF_PIXELS_PER_BEAT),
    localparam int MEM_ADDR_WIDTH = FRAMEBUFFER_SIZE_IN_PIXEL_LG - PPB_LG,
    localparam int STREAM_WIDTH   = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int MEM_WIDTH      = STREAM_WIDTH,
    localparam int MEM_MASK_WIDTH = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            confEnableScissor,
    input  logic [X_BIT_WIDTH-1:0]          confScissorStartX,
    input  logic [X_BIT_WIDTH-1:0]          confScissorEndX,
    input  logic [Y_BIT_WIDTH-1:0]          confScissorStartY,
    input  logic [Y_BIT_WIDTH-1:0]          confScissorEndY,
    input  logic [Y_BIT_WIDTH-1:0]          confYOffset,
    input  logic [X_BIT_WIDTH-1:0]          confXResolution,
    input  logic [Y_BIT_WIDTH-1:0]          confYResolution,
    input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,
    input  logic                            apply,
    output logic                            applied,
    input  logic                            cmdLoad,
    input  logic [FB_SIZE_IN_PIXEL_LG-1:0]  cmdSize,
    output logic                            loadTruncated,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]         s_axis_tdata,
    output logic                            writeEnablePort,
    output logic [MEM_ADDR_WIDTH-1:0]       writeAddrPort,
    output logic [MEM_WIDTH-1:0]            writeDataPort,
    output logic [MEM_MASK_WIDTH-1:0]       writeMaskPort
);

    // Beat counter is at least as wide as cmdSize in beats so oversized loads still terminate.
    localparam int SIZE_W = FB_SIZE_IN_PIXEL_LG - PPB_LG;
    localparam int CNT_W  = (SIZE_W > MEM_ADDR_WIDTH) ? SIZE_W : MEM_ADDR_WIDTH;
    localparam int XW1    = X_BIT_WIDTH + 1;
    localparam logic [Y_BIT_WIDTH-1:0] Y_ONE = 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          index;
    logic [CNT_W-1:0]          size_beats;
    logic [CNT_W-1:0]          size_next;
    logic [X_BIT_WIDTH-1:0]    x;
    logic [Y_BIT_WIDTH-1:0]    y;
    logic [Y_BIT_WIDTH-1:0]    y_top;
    logic [XW1-1:0]            x_adv;
    logic                      x_wrap;
    logic                      handshake;
    logic                      last_beat;
    logic                      sc_en;
    logic [X_BIT_WIDTH-1:0]    sc_sx;
    logic [X_BIT_WIDTH-1:0]    sc_ex;
    logic [Y_BIT_WIDTH-1:0]    sc_sy;
    logic [Y_BIT_WIDTH-1:0]    sc_ey;
    logic [MEM_MASK_WIDTH-1:0] scissor_mask;

    assign size_next = CNT_W'(cmdSize >> PPB_LG);
    assign y_top     = confYOffset + confYResolution - Y_ONE;
    assign x_adv     = {1'b0, x} + XW1'(NUMBER_OF_PIXELS_PER_BEAT);
    assign x_wrap    = (x_adv == {1'b0, confXResolution});
    assign handshake = s_axis_tvalid && s_axis_tready;
    assign last_beat = ((index + CNT_W'(1)) == size_beats);

    always_comb begin
        scissor_mask = '0;
        for (int i = 0; i < NUMBER_OF_PIXELS_PER_BEAT; i++) begin
            logic [XW1-1:0] px;
            logic           pix_on;
            px     = {1'b0, x} + XW1'(i);
            pix_on = !sc_en ||
                     (px >= {1'b0, sc_sx} && px < {1'b0, sc_ex} && y >= sc_sy && y < sc_ey);
            scissor_mask[i*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] = {NUMBER_OF_SUB_PIXELS{pix_on}};
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state           <= IDLE;
            applied         <= 1'b1;
            s_axis_tready   <= 1'b0;
            writeEnablePort <= 1'b0;
            loadTruncated   <= 1'b0;
            writeAddrPort   <= '0;
            writeDataPort   <= '0;
            writeMaskPort   <= '0;
        end else begin
            writeEnablePort <= 1'b0;
            case (state)
                IDLE: begin
                    if (apply && cmdLoad) begin
                        applied       <= 1'b0;
                        loadTruncated <= 1'b0;
                        s_axis_tready <= 1'b1;
                        state         <= (size_next == '0) ? DRAIN : LOAD;
                    end else begin
                        applied <= 1'b1;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        writeEnablePort <= 1'b1;
                        writeAddrPort   <= index[MEM_ADDR_WIDTH-1:0];
                        writeDataPort   <= s_axis_tdata;
                        writeMaskPort   <= {NUMBER_OF_PIXELS_PER_BEAT{confMask}} & scissor_mask;
                        if (last_beat) begin
                            if (s_axis_tlast) begin
                                state         <= IDLE;
                                s_axis_tready <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            state         <= IDLE;
                            s_axis_tready <= 1'b0;
                            loadTruncated <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake && s_axis_tlast) begin
                        state         <= IDLE;
                        s_axis_tready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Position tracking; re-seeded every idle cycle so it needs no reset of its own.
    always_ff @(posedge aclk) begin
        if (state == IDLE) begin
            index      <= '0;
            x          <= '0;
            y          <= y_top;
            size_beats <= size_next;
            if (apply && cmdLoad) begin
                sc_en <= confEnableScissor;
                sc_sx <= confScissorStartX;
                sc_ex <= confScissorEndX;
                sc_sy <= confScissorStartY;
                sc_ey <= confScissorEndY;
            end
        end else if (state == LOAD && handshake) begin
            index <= index + CNT_W'(1);
            if (x_wrap) begin
                x <= '0;
                y <= y - Y_ONE;
            end else begin
                x <= x_adv[X_BIT_WIDTH-1:0];
            end
        end
    end

endmodule
